toom_cook_mul_scheduler: RTL and testbench

Sequencing controller for the 4-way Toom-Cook/schoolbook GF(2) multiplier family. Accepts one 256x256 carry-less multiply request over a valid/ready handshake. Time-shares a single bit-serial limb multiplier across all WAYS^2 limb products a_i*b_j, XOR-accumulating each product into a 512-bit result at offset LIMB_W*(i+j). Replaces the per-product parallel counters with one scheduler, trading latency for area.

---
 rtl/toom_cook_pkg.sv | 36 +++
 rtl/toom_cook_mul_scheduler_clmul.sv | 44 ++++
 rtl/toom_cook_mul_scheduler.sv | 150 +++++++++++++++
 tb/tb_toom_cook_mul_scheduler.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/toom_cook_pkg.sv
// Shared constants, state encoding and limb helpers for the carry-less
// Toom-Cook/schoolbook multiply scheduler.
package toom_cook_pkg;

    localparam int N       = 256;
    localparam int WAYS    = 4;
    localparam int LIMB_W  = N / WAYS;
    localparam int PART_W  = 2 * LIMB_W - 1;
    localparam int NPROD   = WAYS * WAYS;
    localparam int P_W     = $clog2(NPROD);
    localparam int K_W     = $clog2(LIMB_W);
    localparam int IDX_W   = $clog2(WAYS);
    localparam int OFF_W   = $clog2(2 * N);
    localparam int LATENCY = NPROD * (LIMB_W + 1) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [LIMB_W-1:0] limb_sel(input logic [N-1:0] v,
                                                   input logic [IDX_W-1:0] x);
        return v[LIMB_W*x +: LIMB_W];
    endfunction

    // Bit offset of product a_i*b_j inside the double-width result.
    function automatic logic [OFF_W-1:0] limb_offset(input logic [IDX_W-1:0] i,
                                                     input logic [IDX_W-1:0] j);
        logic [OFF_W-1:0] s;
        s = OFF_W'(i) + OFF_W'(j);
        return OFF_W'(LIMB_W) * s;
    endfunction

endpackage

// File: rtl/toom_cook_mul_scheduler_clmul.sv
// Bit-serial LIMB_W x LIMB_W carry-less multiplier: one multiplier bit per step,
// partial product held until the scheduler clears it.
module clmul_limb_serial
    import toom_cook_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              step,
    input  logic [K_W-1:0]    bit_idx,
    input  logic [LIMB_W-1:0] a_limb,
    input  logic [LIMB_W-1:0] b_limb,
    output logic [PART_W-1:0] partial
);

    logic [PART_W-1:0] partial_r;
    logic [PART_W-1:0] partial_next_s;
    logic [PART_W-1:0] b_ext_s;

    // Next partial: clear has priority, otherwise XOR in the shifted B limb.
    always_comb begin
        b_ext_s        = {{(PART_W-LIMB_W){1'b0}}, b_limb};
        partial_next_s = partial_r;
        if (clear) begin
            partial_next_s = '0;
        end else if (step && a_limb[bit_idx]) begin
            partial_next_s = partial_r ^ (b_ext_s << bit_idx);
        end else begin
            partial_next_s = partial_r;
        end
    end

    // Partial product register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            partial_r <= '0;
        end else begin
            partial_r <= partial_next_s;
        end
    end

    assign partial = partial_r;

endmodule

// File: rtl/toom_cook_mul_scheduler.sv
// Time-shares one bit-serial limb multiplier over all WAYS^2 limb products,
// XOR-accumulating each into the 2N-bit carry-less result.
module toom_cook_mul_scheduler
    import toom_cook_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   c,
    output logic             busy,
    output logic [P_W-1:0]   prod_idx
);

    localparam logic [K_W-1:0] K_LAST = K_W'(LIMB_W - 1);
    localparam logic [P_W-1:0] P_LAST = P_W'(NPROD - 1);

    state_t            state_r, state_next_s;
    logic [P_W-1:0]    p_r, p_next_s;
    logic [K_W-1:0]    k_r, k_next_s;
    logic [N-1:0]      a_r, b_r;
    logic [2*N-1:0]    acc_r, acc_next_s;
    logic [2*N-1:0]    c_r, c_next_s;
    logic [2*N-1:0]    part_ext_s;
    logic              in_ready_r, out_valid_r, busy_r;
    logic              load_s, clear_s, step_s;
    logic [LIMB_W-1:0] a_limb_s, b_limb_s;
    logic [OFF_W-1:0]  off_s;
    logic [PART_W-1:0] partial_s;

    assign a_limb_s   = limb_sel(a_r, p_r[P_W-1:IDX_W]);
    assign b_limb_s   = limb_sel(b_r, p_r[IDX_W-1:0]);
    assign off_s      = limb_offset(p_r[P_W-1:IDX_W], p_r[IDX_W-1:0]);
    assign part_ext_s = {{(2*N-PART_W){1'b0}}, partial_s};

    clmul_limb_serial u_clmul (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear_s),
        .step    (step_s),
        .bit_idx (k_r),
        .a_limb  (a_limb_s),
        .b_limb  (b_limb_s),
        .partial (partial_s)
    );

    // Next-state, counter and accumulator logic.
    always_comb begin
        state_next_s = state_r;
        p_next_s     = p_r;
        k_next_s     = k_r;
        acc_next_s   = acc_r;
        c_next_s     = c_r;
        load_s       = 1'b0;
        clear_s      = 1'b0;
        step_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready_r) begin
                    load_s       = 1'b1;
                    clear_s      = 1'b1;
                    acc_next_s   = '0;
                    p_next_s     = '0;
                    k_next_s     = '0;
                    state_next_s = MUL;
                end else begin
                    state_next_s = IDLE;
                end
            end
            MUL: begin
                step_s = 1'b1;
                if (k_r == K_LAST) begin
                    k_next_s     = '0;
                    state_next_s = ACC;
                end else begin
                    k_next_s     = k_r + K_W'(1);
                    state_next_s = MUL;
                end
            end
            ACC: begin
                clear_s    = 1'b1;
                k_next_s   = '0;
                acc_next_s = acc_r ^ (part_ext_s << off_s);
                if (p_r == P_LAST) begin
                    c_next_s     = acc_next_s;
                    p_next_s     = '0;
                    state_next_s = DONE;
                end else begin
                    p_next_s     = p_r + P_W'(1);
                    state_next_s = MUL;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
                p_next_s     = '0;
                k_next_s     = '0;
            end
        endcase
    end

    // State, datapath and registered handshake flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            p_r         <= '0;
            k_r         <= '0;
            a_r         <= '0;
            b_r         <= '0;
            acc_r       <= '0;
            c_r         <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            p_r         <= p_next_s;
            k_r         <= k_next_s;
            acc_r       <= acc_next_s;
            c_r         <= c_next_s;
            in_ready_r  <= (state_next_s == IDLE);
            out_valid_r <= (state_next_s == DONE);
            busy_r      <= (state_next_s == MUL) || (state_next_s == ACC);
            if (load_s) begin
                a_r <= a;
                b_r <= b;
            end else begin
                a_r <= a_r;
                b_r <= b_r;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign prod_idx  = p_r;
    assign c         = c_r;

endmodule

// File: tb/tb_toom_cook_mul_scheduler.sv
// Self-checking bench: directed vector table, back-pressure and reset sequences,
// and randomized operations against a whole-operand GF(2) multiply model.
module tb_toom_cook_mul_scheduler;
    import toom_cook_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   c;
    logic             busy;
    logic [P_W-1:0]   prod_idx;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [N-1:0]   va;
        logic [N-1:0]   vb;
        logic [2*N-1:0] vc;
        int             stall;
    } vec_t;

    vec_t tbl[6];

    toom_cook_mul_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .busy      (busy),
        .prod_idx  (prod_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [2*N-1:0] gf2_mul(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [2*N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++)
            if (x[i]) r ^= ({{N{1'b0}}, y} << i);
        return r;
    endfunction

    function automatic logic [N-1:0] rnd256();
        logic [N-1:0] r;
        for (int w = 0; w < N / 32; w++) r[32*w +: 32] = $urandom;
        return r;
    endfunction

    task automatic check(input string name, input logic [2*N-1:0] got, input logic [2*N-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full request: accept, latency, product order, result, stall, release.
    task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tbv,
                          input logic [2*N-1:0] exp, input int stall, input string name);
        int lat;
        int q[$];
        int bad;
        logic seq_ok;
        logic [2*N-1:0] held;
        for (int t = 0; t < 50 && !in_ready; t++) tick();
        check({name, "_in_ready"}, {511'd0, in_ready}, 512'd1);
        a = ta;
        b = tbv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = rnd256();
        b = rnd256();
        check({name, "_ready_drop"}, {510'd0, in_ready, busy}, 512'd1);
        lat = 1;
        while (!out_valid && lat < LATENCY + 50) begin
            if (busy && (q.size() == 0 || q[$] != int'(prod_idx))) q.push_back(int'(prod_idx));
            in_valid = 1'($urandom_range(0, 1));
            tick();
            lat++;
        end
        in_valid = 1'b0;
        check({name, "_latency"}, 512'(lat), 512'(LATENCY));
        seq_ok = (q.size() == NPROD);
        for (int i = 0; i < q.size(); i++) if (q[i] != i) seq_ok = 1'b0;
        check({name, "_prod_seq"}, {511'd0, seq_ok}, 512'd1);
        check({name, "_c"}, c, exp);
        held = c;
        bad = 0;
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'($urandom_range(0, 1));
            a = rnd256();
            tick();
            if (!out_valid || c !== held || in_ready) bad++;
        end
        in_valid = 1'b0;
        check({name, "_stall_hold"}, 512'(bad), 512'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, "_release"}, {510'd0, out_valid, in_ready}, 512'd1);
    endtask

    initial begin
        logic [N-1:0]   ra, rb;
        logic [N-1:0]   ones;
        logic [2*N-1:0] big;
        int             nv;

        ones = {N{1'b1}};
        big  = 512'd1 << 510;
        tbl[0] = '{va: 256'd1, vb: 256'd1, vc: 512'd1, stall: 0};
        tbl[1] = '{va: 256'd3, vb: 256'd3, vc: 512'd5, stall: 0};
        tbl[2] = '{va: 256'd1 << 255, vb: 256'd1 << 255, vc: big, stall: 2};
        tbl[3] = '{va: 256'd0, vb: ones, vc: 512'd0, stall: 0};
        tbl[4] = '{va: ones, vb: 256'd0, vc: 512'd0, stall: 1};
        tbl[5] = '{va: ones, vb: 256'd1, vc: {256'd0, ones}, stall: 20};

        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        repeat (3) tick();
        check("reset_flags", {509'd0, in_ready, out_valid, busy}, 512'd4);
        check("reset_prod_idx", 512'(prod_idx), 512'd0);
        check("reset_c", c, 512'd0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 6; i++)
            run_op(tbl[i].va, tbl[i].vb, tbl[i].vc, tbl[i].stall, $sformatf("vec%0d", i));

        // Reset in the middle of an operation.
        for (int t = 0; t < 50 && !in_ready; t++) tick();
        a = rnd256();
        b = rnd256();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (499) tick();
        rst = 1'b0;
        tick();
        check("midrst_flags", {509'd0, in_ready, out_valid, busy}, 512'd4);
        check("midrst_prod_idx", 512'(prod_idx), 512'd0);
        check("midrst_c", c, 512'd0);
        rst = 1'b1;
        nv = 0;
        for (int t = 0; t < LATENCY + 60; t++) begin
            tick();
            if (out_valid) nv++;
        end
        check("midrst_no_valid", 512'(nv), 512'd0);
        run_op(ones, 256'd1, {256'd0, ones}, 0, "post_rst");

        // Randomized operands with random back-pressure.
        for (int r = 0; r < 30; r++) begin
            ra = rnd256();
            rb = rnd256();
            if ($urandom_range(0, 3) == 0) ra &= rnd256() & rnd256();
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 255);
            run_op(ra, rb, gf2_mul(ra, rb), $urandom_range(0, 5), $sformatf("rnd%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
